// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - command, ALU and response signals of the ALU operation sequencer
// slave is the sequencer's view; master is the controller/ALU/consumer side.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_cin;
    logic [2:0]       cmd_op;
    logic             cmd_acc;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_cin;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_w;
    logic             alu_zero;
    logic             alu_neg;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_w;
    logic             rsp_zero;
    logic             rsp_neg;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_op, cmd_acc,
        output cmd_ready,
        output alu_a, alu_b, alu_cin, alu_op,
        input  alu_w, alu_zero, alu_neg,
        output rsp_valid, rsp_w, rsp_zero, rsp_neg, op_count,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_op, cmd_acc,
        input  cmd_ready,
        input  alu_a, alu_b, alu_cin, alu_op,
        output alu_w, alu_zero, alu_neg,
        input  rsp_valid, rsp_w, rsp_zero, rsp_neg, op_count,
        output rsp_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - drives registered operands into a combinational ALU and returns the settled result
// One operation in flight: IDLE accepts, SETTLE holds ALU inputs, RESP presents the captured result.
module alu_op_sequencer #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_op_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic             alu_cin_q;
    logic [2:0]       alu_op_q;
    logic [WIDTH-1:0] rsp_w_q;
    logic             rsp_zero_q;
    logic             rsp_neg_q;
    logic             rsp_valid_q;
    logic             cmd_ready_q;
    logic [CNT_W-1:0] op_count_q;

    logic [WIDTH-1:0] opnd_a_d;
    logic [CNT_W-1:0] op_count_d;

    assign opnd_a_d   = bus.cmd_acc ? acc_q : bus.cmd_a;
    assign op_count_d = op_count_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            alu_op_q    <= '0;
            rsp_w_q     <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_neg_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        alu_a_q     <= opnd_a_d;
                        alu_b_q     <= bus.cmd_b;
                        alu_cin_q   <= bus.cmd_cin;
                        alu_op_q    <= bus.cmd_op;
                        cnt_q       <= SETTLE_M1;
                        cmd_ready_q <= 1'b0;
                        state_q     <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    // ALU inputs stay untouched here so the combinational result can settle
                    if (cnt_q == 4'd0) begin
                        rsp_w_q     <= bus.alu_w;
                        rsp_zero_q  <= bus.alu_zero;
                        rsp_neg_q   <= bus.alu_neg;
                        acc_q       <= bus.alu_w;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        op_count_q  <= op_count_d;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_cin   = alu_cin_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_w     = rsp_w_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_neg   = rsp_neg_q;
    assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer with an ALU stub and result scoreboard
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WIDTH(16), .CNT_W(16)) bus ();
    alu_op_sequencer_if #(.WIDTH(16), .CNT_W(16)) bus1 ();

    alu_op_sequencer #(.WIDTH(16), .SETTLE(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    alu_op_sequencer #(.WIDTH(16), .SETTLE(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    // ALU stub: returns {neg, zero, w}
    function automatic logic [17:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic [2:0] op);
        logic [15:0] w;
        case (op)
            3'd0:    w = a + b + {15'd0, cin};
            3'd1:    w = a - b;
            3'd2:    w = a & b;
            3'd3:    w = a | b;
            3'd4:    w = a ^ b;
            default: w = ~a;
        endcase
        return {w[15], (w == 16'd0), w};
    endfunction

    assign {bus.alu_neg, bus.alu_zero, bus.alu_w}    = alu_f(bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_op);
    assign {bus1.alu_neg, bus1.alu_zero, bus1.alu_w} = alu_f(bus1.alu_a, bus1.alu_b, bus1.alu_cin, bus1.alu_op);

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [17:0] sb_q[$];
    logic [15:0] m_acc = 16'd0;
    int          cyc = 0;
    int          acc_edge = 0;
    int          rsp_edge = 0;
    int          hs = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the main DUT: score handshakes that the coming edge will complete.
    task automatic cycle();
        logic        fc;
        logic        fr;
        logic [17:0] e;
        fc = bus.cmd_valid && bus.cmd_ready;
        fr = bus.rsp_valid && bus.rsp_ready;
        if (fr) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("rsp_w", 32'(bus.rsp_w), 32'(e[15:0]));
                check("rsp_zero", 32'(bus.rsp_zero), 32'(e[16]));
                check("rsp_neg", 32'(bus.rsp_neg), 32'(e[17]));
            end
            hs++;
            rsp_edge = cyc + 1;
        end
        if (fc) begin
            e = alu_f(bus.cmd_acc ? m_acc : bus.cmd_a, bus.cmd_b, bus.cmd_cin, bus.cmd_op);
            sb_q.push_back(e);
            m_acc = e[15:0];
            acc_edge = cyc + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (fc) bus.cmd_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic [2:0] op, input logic acc);
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_cin   = cin;
        bus.cmd_op    = op;
        bus.cmd_acc   = acc;
        bus.cmd_valid = 1'b1;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            cycle();
            n++;
        end
        check("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
    endtask

    initial begin
        int          ops;
        int          guard;
        int          acc1[$];
        logic [15:0] e1[$];
        int          first_rsp;
        logic [15:0] w1;

        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_cin = 1'b0;
        bus.cmd_op = '0; bus.cmd_acc = 1'b0; bus.rsp_ready = 1'b0;
        bus1.cmd_valid = 1'b0; bus1.cmd_a = '0; bus1.cmd_b = '0; bus1.cmd_cin = 1'b0;
        bus1.cmd_op = '0; bus1.cmd_acc = 1'b0; bus1.rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_op_count", 32'(bus.op_count), 32'd0);
        check("rst_alu_a", 32'(bus.alu_a), 32'd0);
        check("rst_rsp_w", 32'(bus.rsp_w), 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of SETTLE abandons the operation
        send(16'h1234, 16'h0001, 1'b0, 3'd0, 1'b0);
        cycle();
        check("t1_alu_a_loaded", 32'(bus.alu_a), 32'h1234);
        check("t1_busy", 32'(bus.cmd_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("t1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t1_op_count", 32'(bus.op_count), 32'd0);
        check("t1_alu_a", 32'(bus.alu_a), 32'd0);
        sb_q.delete();
        m_acc = 16'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t1_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end

        // Single op with latency check
        send(16'd100, 16'd2235, 1'b1, 3'd0, 1'b0);
        wait_rsp();
        check("t2_latency", 32'(cyc - acc_edge), 32'd2);
        check("t2_w", 32'(bus.rsp_w), 32'd2336);
        check("t2_zero", 32'(bus.rsp_zero), 32'd0);
        check("t2_neg", 32'(bus.rsp_neg), 32'd0);
        cycle();
        check("t2_op_count", 32'(bus.op_count), 32'd1);

        // Accumulator chaining
        send(16'd5, 16'd3, 1'b0, 3'd0, 1'b0);
        wait_rsp();
        check("t3_w8", 32'(bus.rsp_w), 32'd8);
        cycle();
        send(16'h7777, 16'd8, 1'b0, 3'd1, 1'b1);
        wait_rsp();
        check("t3_w0", 32'(bus.rsp_w), 32'd0);
        check("t3_zero", 32'(bus.rsp_zero), 32'd1);
        cycle();
        send(16'h5555, 16'd1, 1'b0, 3'd1, 1'b1);
        wait_rsp();
        check("t3_wffff", 32'(bus.rsp_w), 32'h0000ffff);
        check("t3_neg", 32'(bus.rsp_neg), 32'd1);
        cycle();
        check("t3_op_count", 32'(bus.op_count), 32'd4);

        // Backpressure with a pending command
        bus.rsp_ready = 1'b0;
        send(16'h4000, 16'h4000, 1'b0, 3'd0, 1'b0);
        wait_rsp();
        send(16'h0010, 16'h0020, 1'b0, 3'd4, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("t4_valid", 32'(bus.rsp_valid), 32'd1);
            check("t4_w", 32'(bus.rsp_w), 32'h8000);
            check("t4_neg", 32'(bus.rsp_neg), 32'd1);
            check("t4_zero", 32'(bus.rsp_zero), 32'd0);
            check("t4_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        cycle();
        bus.rsp_ready = 1'b0;
        check("t4_ready_after", 32'(bus.cmd_ready), 32'd1);
        cycle();
        check("t4_accept_delay", 32'(acc_edge - rsp_edge), 32'd1);
        bus.rsp_ready = 1'b1;
        wait_rsp();
        cycle();
        check("t4_op_count", 32'(bus.op_count), 32'd6);

        // Random stream
        ops = 0;
        guard = 0;
        while ((ops < 3000 || bus.cmd_valid || sb_q.size() > 0 || bus.rsp_valid) && guard < 60000) begin
            if (!bus.cmd_valid && ops < 3000 && $urandom_range(0, 3) != 0) begin
                send(16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                     1'($urandom));
                ops++;
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            guard++;
        end
        check("t5_timeout", 32'(guard < 60000), 32'd1);
        check("t5_sb_empty", 32'(sb_q.size()), 32'd0);
        check("t5_op_count", 32'(bus.op_count), 32'(hs[15:0]));

        // SETTLE=1 instance: back-to-back at 3 cycles/op
        bus1.rsp_ready = 1'b1;
        bus1.cmd_a = 16'd1;
        bus1.cmd_b = 16'd10;
        bus1.cmd_valid = 1'b1;
        first_rsp = -1;
        for (int c = 0; c < 40; c++) begin
            logic f1;
            f1 = bus1.cmd_valid && bus1.cmd_ready;
            if (f1) begin
                acc1.push_back(c + 1);
                e1.push_back(bus1.cmd_a + bus1.cmd_b);
            end
            if (bus1.rsp_valid) begin
                if (first_rsp < 0) first_rsp = c;
                if (e1.size() == 0) begin
                    check("t6_underflow", 32'(e1.size()), 32'd1);
                end else begin
                    w1 = e1.pop_front();
                    check("t6_w", 32'(bus1.rsp_w), 32'(w1));
                end
            end
            @(posedge clk);
            #1;
            if (f1) begin
                bus1.cmd_a = bus1.cmd_a + 16'd1;
                if (acc1.size() == 4) bus1.cmd_valid = 1'b0;
            end
        end
        check("t6_accepts", 32'(acc1.size()), 32'd4);
        if (acc1.size() == 4) begin
            check("t6_latency", 32'(first_rsp - acc1[0]), 32'd1);
            for (int i = 1; i < 4; i++) check("t6_interval", 32'(acc1[i] - acc1[i-1]), 32'd3);
        end
        check("t6_op_count", 32'(bus1.op_count), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
